// File: rtl/jtlabrun_romcache_pkg.sv
// Helpers shared by the ROM cache: byte lane selection from a little-endian refill word.
package jtlabrun_romcache_pkg;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
  endfunction

endpackage

// File: rtl/jtlabrun_romcache_store.sv
// Tag and data array of the ROM cache: one synchronous read port, one write port.
module jtlabrun_romcache_store
  import jtlabrun_romcache_pkg::*;
#(
  parameter int IW = 4,
  parameter int TW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [31:0]   wr_data
);

  logic [TW-1:0] tag_mem  [2**IW];
  logic [31:0]   data_mem [2**IW];
  logic [TW-1:0] rd_tag_q, rd_tag_d;
  logic [31:0]   rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Read returns the pre-write contents when both ports hit the same line.
  always_comb begin
    rd_tag_d  = tag_mem[rd_idx];
    rd_data_d = data_mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_tag_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rd_tag_q  <= rd_tag_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_tag  = rd_tag_q;
  assign rd_data = rd_data_q;

endmodule

// File: rtl/jtlabrun_romcache.sv
// Direct-mapped byte-read cache for the main CPU ROM, refilled one 32-bit SDRAM word per line.
module jtlabrun_romcache
  import jtlabrun_romcache_pkg::*;
#(
  parameter int AW    = 18,
  parameter int LINES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  output logic          sdram_req,
  output logic [AW-3:0] sdram_addr,
  input  logic          sdram_ack,
  input  logic          sdram_dok,
  input  logic [31:0]   sdram_data
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - 2 - IW;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t           state_q;
  logic             sdram_req_q, discard_q, settle_q;
  logic [AW-3:0]    sdram_addr_q;
  logic [AW-1:0]    addr_l_q, addr_l_d;
  logic             valid_l_q, valid_l_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_l;
  logic [31:0]      data_l;
  logic [IW-1:0]    rom_idx, wr_idx;
  logic [TW-1:0]    wr_tag;
  logic             hit, same, fill_done, wr_en;

  assign rom_idx   = rom_addr[2 +: IW];
  assign wr_idx    = sdram_addr_q[IW-1:0];
  assign wr_tag    = sdram_addr_q[AW-3 -: TW];
  assign hit       = valid_l_q && (tag_l == addr_l_q[AW-1 -: TW]);
  assign same      = (addr_l_q == rom_addr);
  assign fill_done = sdram_dok && ((state_q == ST_WAIT) || (state_q == ST_REQ && sdram_ack));
  assign wr_en     = fill_done && !discard_q && !flush;

  jtlabrun_romcache_store #(.IW(IW), .TW(TW)) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (rom_idx),
    .rd_tag  (tag_l),
    .rd_data (data_l),
    .we      (wr_en),
    .wr_idx  (wr_idx),
    .wr_tag  (wr_tag),
    .wr_data (sdram_data)
  );

  always_comb begin
    addr_l_d  = rom_addr;
    valid_l_d = valid_q[rom_idx];
    valid_d   = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_l_q  <= '0;
      valid_l_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      addr_l_q  <= addr_l_d;
      valid_l_q <= valid_l_d;
      valid_q   <= valid_d;
    end
  end

  // settle_q masks the one cycle after a fill where the lookup still shows the old line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      discard_q    <= 1'b0;
      settle_q     <= 1'b0;
    end else begin
      settle_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rom_cs && same && !hit && !settle_q) begin
            sdram_addr_q <= addr_l_q[AW-1:2];
            sdram_req_q  <= 1'b1;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (flush) discard_q <= 1'b1;
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            if (sdram_dok) begin
              state_q   <= ST_IDLE;
              discard_q <= 1'b0;
              settle_q  <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flush) discard_q <= 1'b1;
          if (sdram_dok) begin
            state_q   <= ST_IDLE;
            discard_q <= 1'b0;
            settle_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rom_ok     = rom_cs && hit && same;
  assign rom_data   = byte_sel(data_l, addr_l_q[1:0]);
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

endmodule
